// File: rtl/hpdcache_mem_read_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hpdcache_mem_read_arb
//  Purpose  : Shares one memory read channel among NSRC read requesters.
//             Requests are arbitrated round-robin, tagged with the source
//             index in the upper memory-ID bits and registered in a
//             one-entry output stage. Response beats are routed back to the
//             originating source by ID with zero latency. Each source has a
//             bounded number of in-flight transactions.
//  Ports    : clk_i / rst_ni            clock, async active-low reset
//             src_req_*                 per-source request channels (flat)
//             mem_req_*                 arbitrated memory request channel
//             mem_rsp_*                 memory response channel
//             src_rsp_*                 per-source valid/ready, broadcast payload
//  Revision : 1.0  initial release
// ============================================================================
module hpdcache_mem_read_arb #(
    parameter int NSRC       = 2,
    parameter int ADDR_W     = 56,
    parameter int ID_W       = 7,
    parameter int DATA_W     = 512,
    parameter int MAX_OUTSTD = 4,
    parameter int SRC_W      = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,

    input  logic [NSRC-1:0]          src_req_valid_i,
    output logic [NSRC-1:0]          src_req_ready_o,
    input  logic [NSRC*ADDR_W-1:0]   src_req_addr_i,
    input  logic [NSRC*8-1:0]        src_req_len_i,
    input  logic [NSRC*3-1:0]        src_req_size_i,
    input  logic [NSRC*ID_W-1:0]     src_req_id_i,

    output logic                     mem_req_valid_o,
    input  logic                     mem_req_ready_i,
    output logic [ADDR_W-1:0]        mem_req_addr_o,
    output logic [7:0]               mem_req_len_o,
    output logic [2:0]               mem_req_size_o,
    output logic [ID_W+SRC_W-1:0]    mem_req_id_o,

    input  logic                     mem_rsp_valid_i,
    output logic                     mem_rsp_ready_o,
    input  logic [ID_W+SRC_W-1:0]    mem_rsp_id_i,
    input  logic [DATA_W-1:0]        mem_rsp_data_i,
    input  logic                     mem_rsp_error_i,
    input  logic                     mem_rsp_last_i,

    output logic [NSRC-1:0]          src_rsp_valid_o,
    input  logic [NSRC-1:0]          src_rsp_ready_i,
    output logic [ID_W-1:0]          src_rsp_id_o,
    output logic [DATA_W-1:0]        src_rsp_data_o,
    output logic                     src_rsp_error_o,
    output logic                     src_rsp_last_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTD + 1);
    localparam logic [CNT_W-1:0] c_outstd_max = CNT_W'(MAX_OUTSTD);
    localparam logic [SRC_W-1:0] c_src_last   = SRC_W'(NSRC - 1);

    // Output stage state
    localparam logic [0:0] c_st_empty = 1'b0;
    localparam logic [0:0] c_st_full  = 1'b1;

    logic [0:0]            r_state;
    logic [SRC_W-1:0]      r_ptr;
    logic [CNT_W-1:0]      r_outstd [NSRC];
    logic [ADDR_W-1:0]     r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [ID_W+SRC_W-1:0] r_id;

    logic [NSRC-1:0]       w_elig;
    logic [NSRC-1:0]       w_mask_hi;
    logic                  w_any;
    logic [SRC_W-1:0]      w_grant;
    logic                  w_can_load;
    logic                  w_load;
    logic [NSRC-1:0]       w_inc;
    logic [NSRC-1:0]       w_dec;
    logic [NSRC-1:0]       w_rsp_hit;
    logic                  w_src_ok;
    logic [SRC_W-1:0]      w_rsp_src;
    logic                  w_rsp_hs_last;
    logic [ADDR_W-1:0]     w_sel_addr;
    logic [7:0]            w_sel_len;
    logic [2:0]            w_sel_size;
    logic [ID_W-1:0]       w_sel_id;

    // ------------------------------------------------------------------
    // Per-source eligibility, response decode and counter strobes
    // ------------------------------------------------------------------
    assign w_rsp_src     = mem_rsp_id_i[ID_W +: SRC_W];
    assign w_rsp_hs_last = mem_rsp_valid_i & mem_rsp_ready_o & mem_rsp_last_i;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            assign w_elig[gi]          = src_req_valid_i[gi] && (r_outstd[gi] < c_outstd_max);
            assign w_rsp_hit[gi]       = (w_rsp_src == SRC_W'(gi));
            assign w_inc[gi]           = w_load && (w_grant == SRC_W'(gi));
            assign w_dec[gi]           = w_rsp_hs_last & w_rsp_hit[gi];
            assign src_req_ready_o[gi] = w_inc[gi];
            assign src_rsp_valid_o[gi] = mem_rsp_valid_i & w_rsp_hit[gi];
        end
    endgenerate

    // An ID whose source field decodes to no requester can only appear when
    // NSRC is not a power of two; such beats are swallowed.
    assign w_src_ok        = |w_rsp_hit;
    assign mem_rsp_ready_o = w_src_ok ? |(src_rsp_ready_i & w_rsp_hit) : 1'b1;
    assign src_rsp_id_o    = mem_rsp_id_i[ID_W-1:0];
    assign src_rsp_data_o  = mem_rsp_data_i;
    assign src_rsp_error_o = mem_rsp_error_i;
    assign src_rsp_last_o  = mem_rsp_last_i;

    // ------------------------------------------------------------------
    // Round-robin grant: sources at or above the pointer take priority;
    // if none of them is eligible, fall back to the lowest eligible index.
    // ------------------------------------------------------------------
    always_comb begin
        logic v_seen;
        v_seen    = 1'b0;
        w_mask_hi = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (SRC_W'(i) == r_ptr) begin
                v_seen = 1'b1;
            end
            w_mask_hi[i] = v_seen;
        end
    end

    always_comb begin
        logic [NSRC-1:0] v_hi;
        v_hi    = w_elig & w_mask_hi;
        w_any   = |w_elig;
        w_grant = '0;
        // Descending scan so the lowest matching index wins.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_elig[i] && (v_hi == '0)) begin
                w_grant = SRC_W'(i);
            end
        end
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v_hi[i]) begin
                w_grant = SRC_W'(i);
            end
        end
    end

    // Output stage may take a new request when empty or draining this cycle.
    assign w_can_load = (r_state == c_st_empty) || mem_req_ready_i;
    assign w_load     = w_can_load && w_any;

    always_comb begin
        w_sel_addr = '0;
        w_sel_len  = '0;
        w_sel_size = '0;
        w_sel_id   = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (w_grant == SRC_W'(i)) begin
                w_sel_addr = src_req_addr_i[i*ADDR_W +: ADDR_W];
                w_sel_len  = src_req_len_i[i*8 +: 8];
                w_sel_size = src_req_size_i[i*3 +: 3];
                w_sel_id   = src_req_id_i[i*ID_W +: ID_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage, pointer and outstanding counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_st_empty;
            r_ptr   <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_id    <= '0;
        end else begin
            if (w_load) begin
                r_state <= c_st_full;
                r_ptr   <= (w_grant == c_src_last) ? '0 : w_grant + SRC_W'(1);
                r_addr  <= w_sel_addr;
                r_len   <= w_sel_len;
                r_size  <= w_sel_size;
                r_id    <= {w_grant, w_sel_id};
            end else if ((r_state == c_st_full) && mem_req_ready_i) begin
                r_state <= c_st_empty;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NSRC; i++) begin
                r_outstd[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                case ({w_inc[i], w_dec[i]})
                    2'b10:   r_outstd[i] <= r_outstd[i] + CNT_W'(1);
                    2'b01:   r_outstd[i] <= r_outstd[i] - CNT_W'(1);
                    default: r_outstd[i] <= r_outstd[i];
                endcase
            end
        end
    end

    assign mem_req_valid_o = (r_state == c_st_full);
    assign mem_req_addr_o  = r_addr;
    assign mem_req_len_o   = r_len;
    assign mem_req_size_o  = r_size;
    assign mem_req_id_o    = r_id;

`ifndef SYNTHESIS
    a_rsp_src_in_range : assert property (
        @(posedge clk_i) disable iff (!rst_ni) mem_rsp_valid_i |-> w_src_ok);

    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_chk
            a_no_underflow : assert property (
                @(posedge clk_i) disable iff (!rst_ni) w_dec[gi] |-> (r_outstd[gi] != '0));
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: doc/hpdcache_mem_read_arb.md
Name: hpdcache_mem_read_arb

Overview:
- Shares one memory read channel (request + response) among NSRC read requesters, e.g. several HPDcache instances, or an HPDcache plus an instruction-cache refill port.
- Arbitrates requests round-robin and extends the memory ID with the source index.
- Registers the granted request in a one-entry output stage.
- Routes response beats back to their source by ID and bounds per-source outstanding transactions.

Parameters:
- NSRC, 2, number of requesters (>=2).
- ADDR_W, 56, memory address width.
- ID_W, 7, requester-side transaction ID width.
- DATA_W, 512, response data width.
- MAX_OUTSTD, 4, maximum in-flight read transactions per source (>=1).
- SRC_W, $clog2(NSRC), derived; memory-side ID width = ID_W+SRC_W.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- src_req_valid_i  in  NSRC  per-source request valid
- src_req_ready_o  out  NSRC  per-source request ready
- src_req_addr_i  in  NSRC*ADDR_W  request address
- src_req_len_i  in  NSRC*8  beats minus one
- src_req_size_i  in  NSRC*3  log2 bytes per beat
- src_req_id_i  in  NSRC*ID_W  transaction ID
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory request ready
- mem_req_addr_o  out  ADDR_W
- mem_req_len_o  out  8
- mem_req_size_o  out  3
- mem_req_id_o  out  ID_W+SRC_W  {src index, src id}
- mem_rsp_valid_i  in  1  response beat valid
- mem_rsp_ready_o  out  1  response beat ready
- mem_rsp_id_i  in  ID_W+SRC_W  response ID
- mem_rsp_data_i  in  DATA_W
- mem_rsp_error_i  in  1
- mem_rsp_last_i  in  1  last beat of transaction
- src_rsp_valid_o  out  NSRC
- src_rsp_ready_i  in  NSRC
- src_rsp_id_o  out  ID_W  broadcast to all sources
- src_rsp_data_o  out  DATA_W  broadcast
- src_rsp_error_o  out  1  broadcast
- src_rsp_last_o  out  1  broadcast

Behaviour:
- Reset (async assert, sync release): mem_req_valid_o=0; output register payload=0; RR pointer=0; all outstanding counters=0.
- Eligibility: source i is eligible when src_req_valid_i[i]=1 and outstd[i] < MAX_OUTSTD.
- Output stage states:
  - EMPTY: accept a new grant.
  - FULL: hold the stored payload.
  - FULL->EMPTY when mem_req_ready_i=1 and no new grant is loaded the same cycle.
- Stage loads when EMPTY, or when FULL with mem_req_ready_i=1 (back-to-back; 1 req/cycle throughput).
- Grant: among eligible sources, the first at or after the RR pointer, wrapping at NSRC-1 -> 0.
  - On load, src_req_ready_o[grant]=1 and all other readies are 0.
  - The pointer then moves to grant+1 mod NSRC.
  - No eligible source: pointer unchanged.
- src_req_ready_o is 0 for every source whenever the stage cannot load.
- Latency: a request accepted in cycle N presents mem_req_valid_o in cycle N+1.
- Output payload is stable while mem_req_valid_o=1 and mem_req_ready_i=0.
- Outstanding counter outstd[i]:
  - +1 on the cycle source i's request is loaded.
  - -1 on a response handshake with last=1 and ID source field = i.
  - Both in the same cycle: net unchanged.
  - Never exceeds MAX_OUTSTD; a source at MAX_OUTSTD is skipped by the arbiter.
- Response path (combinational, zero latency):
  - s = mem_rsp_id_i[ID_W+SRC_W-1:ID_W].
  - src_rsp_valid_o[s] = mem_rsp_valid_i; all other src_rsp_valid_o bits = 0.
  - mem_rsp_ready_o = src_rsp_ready_i[s].
  - src_rsp_id_o = low ID_W bits of mem_rsp_id_i; data, error and last pass through unmodified.
- s >= NSRC (non-power-of-2 NSRC): beat is consumed (mem_rsp_ready_o=1), dropped, and no counter changes.
  - Simulation assertion fires.
  - Also assert: decrement with outstd=0 never occurs.
- Reset mid-transaction: all state cleared; in-flight responses after reset are a system-level error and are not recovered.

Test Plan:
- NSRC=2, both sources always valid, mem_req_ready_i=1 -> grants alternate 0,1,0,1; one mem request per cycle after 1-cycle fill; mem_req_id_o[7]=source index.
- Source 1 issues id=0x15, addr=0x1000, len=3 with mem_req_ready_i held 0 for 5 cycles -> mem_req_* stable at {1,0x15},0x1000,3; src_req_ready_o=00 during the stall; release -> handshake in one cycle.
- MAX_OUTSTD=4: source 0 issues 5 requests with no responses while source 1 is idle -> 4 issued; 5th blocked (ready=0); last-beat response for source 0 -> 5th issued next cycle.
- Response id={1,0x2A}, last=1 with src_rsp_ready_i=01 -> src_rsp_valid_o=10 and mem_rsp_ready_o=0 until src_rsp_ready_i[1]=1; then outstd[1] decrements by 1.
- Same-cycle request load and last-beat response for source 0 at outstd=2 -> outstd stays 2.
- Assert rst_ni while mem_req_valid_o=1 -> mem_req_valid_o=0 immediately (async); counters and RR pointer=0; first post-reset grant goes to source 0.
